// File: rtl/operand_fetch.sv
// Operand-fetch stage: register file, pending-write scoreboard, RAW stall and a registered
// bundle for the ALU. Define OPFETCH_BYPASS_EN to forward same-cycle writebacks to the sources.
module operand_fetch #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned ADDR_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_opcode,
  input  logic [2:0]        in_cc,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic [ADDR_W-1:0] in_rs_a,
  input  logic [ADDR_W-1:0] in_rs_b,
  input  logic              in_use_imm,
  input  logic [WIDTH-1:0]  in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4:0]        out_opcode,
  output logic [2:0]        out_cc,
  output logic [ADDR_W-1:0] out_rd,
  output logic [WIDTH-1:0]  out_data_a,
  output logic [WIDTH-1:0]  out_data_b,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [WIDTH-1:0]  wb_data
);

  logic [WIDTH-1:0]    rf_q [NUM_REGS];
  logic [NUM_REGS-1:0] pending_q;

  logic             byp_a, byp_b;
  logic             haz_a, haz_b;
  logic             accept;
  logic [WIDTH-1:0] rf_a, rf_b;
  logic [WIDTH-1:0] opnd_a, opnd_b;

  always_comb begin
    rf_a = (in_rs_a == '0) ? '0 : rf_q[in_rs_a];
    rf_b = (in_rs_b == '0) ? '0 : rf_q[in_rs_b];
`ifdef OPFETCH_BYPASS_EN
    byp_a = wb_en && (wb_rd == in_rs_a) && (in_rs_a != '0);
    byp_b = wb_en && (wb_rd == in_rs_b) && (in_rs_b != '0);
`else
    byp_a = 1'b0;
    byp_b = 1'b0;
`endif
    opnd_a = byp_a ? wb_data : rf_a;
    opnd_b = in_use_imm ? in_imm : (byp_b ? wb_data : rf_b);
    haz_a  = (in_rs_a != '0) && pending_q[in_rs_a] && !byp_a;
    haz_b  = !in_use_imm && (in_rs_b != '0) && pending_q[in_rs_b] && !byp_b;
  end

  assign in_ready = !rst && (!out_valid || out_ready) && !(haz_a || haz_b);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        rf_q[i] <= '0;
      end
    end else if (wb_en && (wb_rd != '0)) begin
      rf_q[wb_rd] <= wb_data;
    end
  end

  // A newly accepted writer takes priority over the older writer retiring on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
    end else begin
      pending_q[0] <= 1'b0;
      for (int i = 1; i < int'(NUM_REGS); i++) begin
        if (accept && (in_rd == ADDR_W'(i))) begin
          pending_q[i] <= 1'b1;
        end else if (wb_en && (wb_rd == ADDR_W'(i))) begin
          pending_q[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_opcode <= '0;
      out_cc     <= '0;
      out_rd     <= '0;
      out_data_a <= '0;
      out_data_b <= '0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      out_opcode <= in_opcode;
      out_cc     <= in_cc;
      out_rd     <= in_rd;
      out_data_a <= opnd_a;
      out_data_b <= opnd_b;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: vector table plus hand sequences for stall, backpressure
// and scoreboard set/clear collision. Expectations follow the OPFETCH_BYPASS_EN setting.
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [4:0]  in_opcode;
  logic [2:0]  in_cc;
  logic [4:0]  in_rd, in_rs_a, in_rs_b;
  logic        in_use_imm;
  logic [31:0] in_imm;
  logic        out_valid, out_ready;
  logic [4:0]  out_opcode;
  logic [2:0]  out_cc;
  logic [4:0]  out_rd;
  logic [31:0] out_data_a, out_data_b;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int checks   = 0;
  int failures = 0;

  operand_fetch dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_opcode  (in_opcode),
    .in_cc      (in_cc),
    .in_rd      (in_rd),
    .in_rs_a    (in_rs_a),
    .in_rs_b    (in_rs_b),
    .in_use_imm (in_use_imm),
    .in_imm     (in_imm),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_opcode (out_opcode),
    .out_cc     (out_cc),
    .out_rd     (out_rd),
    .out_data_a (out_data_a),
    .out_data_b (out_data_b),
    .wb_en      (wb_en),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [4:0]  rd, rs_a, rs_b;
    logic        use_imm;
    logic [31:0] imm;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        oready;
    logic        e_ready, e_ovalid;
    logic [31:0] e_a, e_b;
    logic [4:0]  e_rd;
  } vec_t;

  function automatic vec_t mk(logic v, logic [4:0] rd, logic [4:0] ra, logic [4:0] rb,
                              logic ui, logic [31:0] imm, logic we, logic [4:0] wr,
                              logic [31:0] wd, logic ordy, logic er, logic eov,
                              logic [31:0] ea, logic [31:0] eb, logic [4:0] erd);
    vec_t t;
    t.valid = v;  t.rd = rd;  t.rs_a = ra;  t.rs_b = rb;  t.use_imm = ui;  t.imm = imm;
    t.wb_en = we; t.wb_rd = wr; t.wb_data = wd; t.oready = ordy;
    t.e_ready = er; t.e_ovalid = eov; t.e_a = ea; t.e_b = eb; t.e_rd = erd;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    in_valid   = v.valid;
    in_rd      = v.rd;
    in_rs_a    = v.rs_a;
    in_rs_b    = v.rs_b;
    in_use_imm = v.use_imm;
    in_imm     = v.imm;
    wb_en      = v.wb_en;
    wb_rd      = v.wb_rd;
    wb_data    = v.wb_data;
    out_ready  = v.oready;
  endtask

  // Drive one cycle, check in_ready before the edge and the output bundle after it.
  task automatic step(input vec_t v, input string tag);
    drive(v);
    #1;
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(v.e_ready));
    tick();
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(v.e_ovalid));
    chk({tag, ".out_data_a"}, out_data_a, v.e_a);
    chk({tag, ".out_data_b"}, out_data_b, v.e_b);
    chk({tag, ".out_rd"}, 32'(out_rd), 32'(v.e_rd));
  endtask

  vec_t tbl [14];

  initial begin
    //            v  rd rsa rsb ui imm        we wr wd            ordy rdy ov a      b      erd
    tbl[0]  = mk(0, 0, 0, 0, 0, 32'h0,     1, 1, 32'h11,       1, 1, 0, 32'h0,  32'h5,  1);
    tbl[1]  = mk(0, 0, 0, 0, 0, 32'h0,     1, 2, 32'h22,       1, 1, 0, 32'h0,  32'h5,  1);
    tbl[2]  = mk(1, 0, 1, 2, 0, 32'h0,     0, 0, 32'h0,        1, 1, 1, 32'h11, 32'h22, 0);
    tbl[3]  = mk(1, 0, 2, 0, 1, 32'h7,     0, 0, 32'h0,        1, 1, 1, 32'h22, 32'h7,  0);
    tbl[4]  = mk(0, 0, 0, 0, 0, 32'h0,     0, 0, 32'h0,        1, 1, 0, 32'h22, 32'h7,  0);
    tbl[5]  = mk(0, 0, 0, 0, 0, 32'h0,     1, 0, 32'hFFFFFFFF, 1, 1, 0, 32'h22, 32'h7,  0);
    tbl[6]  = mk(1, 0, 0, 0, 0, 32'h0,     0, 0, 32'h0,        1, 1, 1, 32'h0,  32'h0,  0);
    tbl[7]  = mk(1, 4, 1, 0, 1, 32'h100,   0, 0, 32'h0,        1, 1, 1, 32'h11, 32'h100, 4);
    tbl[8]  = mk(1, 6, 1, 4, 1, 32'h55,    0, 0, 32'h0,        1, 1, 1, 32'h11, 32'h55, 6);
    tbl[9]  = mk(1, 0, 2, 4, 0, 32'h0,     0, 0, 32'h0,        1, 0, 0, 32'h11, 32'h55, 6);
    tbl[10] = mk(0, 0, 0, 0, 0, 32'h0,     1, 4, 32'h44,       1, 1, 0, 32'h11, 32'h55, 6);
    tbl[11] = mk(1, 0, 2, 4, 0, 32'h0,     0, 0, 32'h0,        1, 1, 1, 32'h22, 32'h44, 0);
    tbl[12] = mk(0, 0, 0, 0, 0, 32'h0,     1, 6, 32'h66,       1, 1, 0, 32'h22, 32'h44, 0);
    tbl[13] = mk(1, 7, 6, 6, 0, 32'h0,     0, 0, 32'h0,        1, 1, 1, 32'h66, 32'h66, 7);

    // Reset held 2 cycles with a valid instruction waiting: ADD r1, r0, #5.
    drive(mk(1, 1, 0, 0, 1, 32'h5, 0, 0, 32'h0, 1, 0, 0, 0, 0, 0));
    in_opcode = 5'd1;
    in_cc     = 3'd2;
    rst       = 1'b1;
    tick();
    tick();
    chk("rst.in_ready", 32'(in_ready), 32'd0);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.out_data_a", out_data_a, 32'h0);
    chk("rst.out_data_b", out_data_b, 32'h0);
    chk("rst.out_rd", 32'(out_rd), 32'd0);
    chk("rst.out_opcode", 32'(out_opcode), 32'd0);
    chk("rst.out_cc", 32'(out_cc), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst.in_ready", 32'(in_ready), 32'd1);
    tick();
    chk("post_rst.out_valid", 32'(out_valid), 32'd1);
    chk("post_rst.out_data_a", out_data_a, 32'h0);
    chk("post_rst.out_data_b", out_data_b, 32'h5);
    chk("post_rst.out_rd", 32'(out_rd), 32'd1);
    chk("post_rst.out_opcode", 32'(out_opcode), 32'd1);
    chk("post_rst.out_cc", 32'(out_cc), 32'd2);

    for (int i = 0; i < 14; i++) begin
      step(tbl[i], $sformatf("vec%0d", i));
    end

    // RAW: ADD r3 then SUB reading r3, writeback r3=0x2A after two stall cycles.
    in_opcode = 5'd2;
    step(mk(1, 3, 0, 0, 1, 32'h0, 0, 0, 32'h0,  1, 1, 1, 32'h0, 32'h0, 3), "raw.add");
    step(mk(1, 8, 3, 0, 1, 32'h1, 0, 0, 32'h0,  1, 0, 0, 32'h0, 32'h0, 3), "raw.stall0");
    step(mk(1, 8, 3, 0, 1, 32'h1, 0, 0, 32'h0,  1, 0, 0, 32'h0, 32'h0, 3), "raw.stall1");
`ifdef OPFETCH_BYPASS_EN
    step(mk(1, 8, 3, 0, 1, 32'h1, 1, 3, 32'h2A, 1, 1, 1, 32'h2A, 32'h1, 8), "raw.wb");
`else
    step(mk(1, 8, 3, 0, 1, 32'h1, 1, 3, 32'h2A, 1, 0, 0, 32'h0, 32'h0, 3), "raw.wb");
    step(mk(1, 8, 3, 0, 1, 32'h1, 0, 0, 32'h0,  1, 1, 1, 32'h2A, 32'h1, 8), "raw.after");
`endif

    // Backpressure: SUB bundle must hold for 3 cycles while a new instruction waits.
    for (int i = 0; i < 3; i++) begin
      step(mk(1, 0, 2, 0, 1, 32'h9, 0, 0, 32'h0, 0, 0, 1, 32'h2A, 32'h1, 8),
           $sformatf("bp.hold%0d", i));
      in_opcode = 5'd3;
      chk($sformatf("bp.hold%0d.out_opcode", i), 32'(out_opcode), 32'd2);
    end
    step(mk(1, 0, 2, 0, 1, 32'h9, 0, 0, 32'h0, 1, 1, 1, 32'h22, 32'h9, 0), "bp.release");
    chk("bp.release.out_opcode", 32'(out_opcode), 32'd3);
    step(mk(0, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 1, 1, 0, 32'h22, 32'h9, 0), "bp.drain");

    // Collision: second writer of r5 accepted on the edge the first writer retires.
    step(mk(1, 5, 0, 0, 1, 32'h0, 0, 0, 32'h0,  1, 1, 1, 32'h0, 32'h0, 5), "col.w1");
    step(mk(1, 5, 0, 0, 1, 32'h0, 1, 5, 32'h50, 1, 1, 1, 32'h0, 32'h0, 5), "col.w2");
    step(mk(1, 0, 5, 0, 1, 32'h3, 0, 0, 32'h0,  1, 0, 0, 32'h0, 32'h0, 5), "col.stall0");
    step(mk(1, 0, 5, 0, 1, 32'h3, 0, 0, 32'h0,  1, 0, 0, 32'h0, 32'h0, 5), "col.stall1");
`ifdef OPFETCH_BYPASS_EN
    step(mk(1, 0, 5, 0, 1, 32'h3, 1, 5, 32'h51, 1, 1, 1, 32'h51, 32'h3, 0), "col.wb");
`else
    step(mk(1, 0, 5, 0, 1, 32'h3, 1, 5, 32'h51, 1, 0, 0, 32'h0, 32'h0, 5), "col.wb");
    step(mk(1, 0, 5, 0, 1, 32'h3, 0, 0, 32'h0,  1, 1, 1, 32'h51, 32'h3, 0), "col.after");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
# operand_fetch

Operand-fetch stage sitting directly upstream of the ALU. It holds the `WIDTH`-bit general register file and tracks pending writes in a per-register scoreboard. It accepts decoded instructions over a valid/ready handshake and reads or bypasses both source operands. It stalls on read-after-write hazards and presents a registered opcode/cc/operand bundle to the ALU stage.

## Interface
- `NUM_REGS`, 32, number of architectural registers; r0 reads as zero and is never written.
- `ADDR_W`, 5, register index width; `NUM_REGS` must equal 2**`ADDR_W`.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `in_valid` in 1: decoded instruction present.
- `in_ready` out 1: stage accepts the instruction this cycle.
- `in_opcode` in 5: ALU opcode (`ADD`..`CMP` encodings from defines.vh).
- `in_cc` in 3: compare condition code.
- `in_rd` in `ADDR_W`: destination register.
- `in_rs_a`, `in_rs_b` in `ADDR_W`: source registers.
- `in_use_imm` in 1: operand B is taken from `in_imm`; `in_rs_b` is ignored.
- `in_imm` in `WIDTH`: immediate value.
- `out_valid` out 1: bundle valid for the ALU.
- `out_ready` in 1: ALU stage consumes the bundle.
- `out_opcode` out 5, `out_cc` out 3, `out_rd` out `ADDR_W`: registered copies of the inputs.
- `out_data_a`, `out_data_b` out `WIDTH`: resolved operands.
- `wb_en` in 1: writeback of an ALU result.
- `wb_rd` in `ADDR_W`: writeback destination.
- `wb_data` in `WIDTH`: writeback value.

## Operation
- **Register file.** 1 write port from writeback and 2 combinational read ports. Writes with `wb_rd`=0 are dropped.
- **Scoreboard.** One `pending` bit per register, bit 0 hardwired to 0.
  - Set when an instruction is accepted with `in_rd`≠0.
  - Cleared on `wb_en` to that register.
  - If set and clear hit the same register in the same cycle, set wins, because the newer writer is in flight.
- **Source hazard.** A source is hazardous when its index is ≠0 and its `pending` bit is set, unless it is bypassed (see Configuration).
  - `rs_b` is checked only when `in_use_imm`=0.
- **Handshake.**
  - `in_ready` = (`!out_valid` || `out_ready`) && `!hazard`. It is combinational on the `in_*` fields.
  - Accept occurs when `in_valid` && `in_ready`.
  - On accept, the output register loads opcode, cc, rd, and both operands, and `out_valid` becomes 1.
  - When `out_ready` && `out_valid` and there is no accept, `out_valid` becomes 0.
  - While `out_valid` && `!out_ready`, all `out_*` signals hold stable.
- **Operand A** is the register value, or 0 for r0.
- **Operand B** is `in_imm` if `in_use_imm`=1, otherwise the register value.
- **No per-opcode decode.** Every accepted instruction with `in_rd`≠0 marks its destination pending, CMP included.
- **Reset.**
  - `out_valid`=0, all `out_*` data/fields=0, all `pending`=0, all registers=0.
  - `in_ready` reads 1 the cycle after reset deasserts.
  - Reset mid-stall or mid-hold discards the in-flight bundle and all scoreboard state. Writebacks arriving during reset are ignored.

## Timing
- Accept to `out_valid`: 1 cycle (registered).
- Throughput: 1 instruction/cycle when there are no hazards and `out_ready`=1.
- Writeback to a register is visible to the register file on the next edge.
- The pending bit clears on the same edge as the register file write.
- Back-to-back dependent instructions (B uses A's rd) stall until A's writeback.
  - Stall length equals the downstream latency from accept to `wb_en`. With bypass enabled it is 1 cycle shorter.
- `out_ready`=0 with `out_valid`=1 forces `in_ready`=0, whatever the hazard state.

## Configuration
- `OPFETCH_BYPASS_EN` defined:
  - A source matching `wb_rd` while `wb_en`=1 (index ≠0) reads `wb_data` in the same cycle.
  - That source is not treated as hazardous, even though its `pending` bit is still set.
- `OPFETCH_BYPASS_EN` undefined:
  - There is no bypass path, and sources read only the register file.
  - A source whose writeback is arriving this cycle stalls one extra cycle.
  - It is accepted the following cycle with the written value.

## Test plan
- **Reset.** Assert `rst` for 2 cycles with `in_valid`=1. Required: `out_valid`=0, all outputs 0, and no accept. Then ADD r1,r0,imm=5 is accepted and `out_data_a`=0, `out_data_b`=5 one cycle later.
- **RAW stall.** Issue ADD rd=r3, then SUB rs_a=r3. Required: `in_ready`=0 until `wb_en`, `wb_rd`=3, `wb_data`=0x2A. With bypass, SUB is accepted that cycle with `out_data_a`=0x2A. Without bypass, it is accepted 1 cycle later with the same value.
- **Backpressure.** Set `out_ready`=0 for 3 cycles while `out_valid`=1. Required: `out_*` are stable, `in_ready`=0, and no instruction is lost or duplicated after release.
- **Immediate masking.** Use `in_use_imm`=1 with `in_rs_b`=r4 pending. Required: no stall, and `out_data_b`=`in_imm`.
- **Set/clear collision.** In the same cycle, accept an instruction with rd=r5 while `wb_en` targets r5 (older writer). Required: r5 stays pending, and a later reader of r5 stalls until the second writeback.
- **r0 rules.** Writeback r0=0xFFFFFFFF, then read r0. Required: operand 0, and an instruction with rd=r0 never causes a stall.
